// File: rtl/arbitro_escritura_memoria_pkg.sv
// Shared constants and helpers for the register-bank write arbiter.
// Optional feature macro used by this slice: ARB_STATS_EN (per-requester grant counters).
package arbitro_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREG   = 16;

    // Wrap is an explicit compare so non-power-of-two requester counts work.
    function automatic logic [2:0] rr_next(input logic [2:0] ptr, input int nreq);
        if (int'(ptr) >= nreq - 1) begin
            return 3'd0;
        end
        return ptr + 3'd1;
    endfunction

endpackage

// File: rtl/arbitro_escritura_memoria_if.sv
// Request/bank-write bundle between the requesters (master) and the arbiter (slave).
// With ARB_STATS_EN defined it also carries stats_clr and the flattened grant_cnt.
interface arbitro_escritura_memoria_if
    import arbitro_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int N    = DATA_W,
    parameter int AW   = ADDR_W
) ();

    logic                 arb_en;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*N-1:0]    req_data;
    logic [NREQ-1:0]      req_ack;
    logic                 mem_w;
    logic [AW-1:0]        mem_sel;
    logic [N-1:0]         mem_s;
    logic [2:0]           grant_id;
    logic                 busy;

`ifdef ARB_STATS_EN
    logic                 stats_clr;
    logic [NREQ*16-1:0]   grant_cnt;

    modport master (
        output arb_en, req_valid, req_addr, req_data, stats_clr,
        input  req_ack, mem_w, mem_sel, mem_s, grant_id, busy, grant_cnt
    );

    modport slave (
        input  arb_en, req_valid, req_addr, req_data, stats_clr,
        output req_ack, mem_w, mem_sel, mem_s, grant_id, busy, grant_cnt
    );
`else
    modport master (
        output arb_en, req_valid, req_addr, req_data,
        input  req_ack, mem_w, mem_sel, mem_s, grant_id, busy
    );

    modport slave (
        input  arb_en, req_valid, req_addr, req_data,
        output req_ack, mem_w, mem_sel, mem_s, grant_id, busy
    );
`endif

endinterface

// File: rtl/arbitro_escritura_memoria_rr_picker.sv
// Combinational round-robin search: first eligible requester at or after ptr, wrapping.
module rr_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] elig,
    input  logic [2:0]      ptr,
    output logic            found,
    output logic [2:0]      winner
);

    logic [3:0]      idx;
    logic [NREQ-1:0] shifted;

    // Scan NREQ positions starting from ptr; the first hit wins.
    always_comb begin
        found   = 1'b0;
        winner  = 3'd0;
        idx     = 4'd0;
        shifted = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end
            shifted = elig >> idx;
            if (!found && shifted[0]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

endmodule

// File: rtl/arbitro_escritura_memoria.sv
// Round-robin arbiter for the single write port of the 16x16 register bank.
// Define ARB_STATS_EN to add saturating per-requester grant counters with stats_clr.
module arbitro_escritura_memoria
    import arbitro_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int N    = DATA_W,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                        clk,
    input  logic                        rst,
    arbitro_escritura_memoria_if.slave  bus
);

    logic [NREQ-1:0] elig;
    logic            found;
    logic [2:0]      winner;
    logic [2:0]      ptr;
    logic            grant;

    // A requester still holding valid during its ack cycle must not win twice.
    assign elig     = bus.req_valid & ~bus.req_ack;
    assign bus.busy = |elig;
    assign grant    = bus.arb_en & found;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .elig   (elig),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_w    <= 1'b0;
            bus.mem_sel  <= '0;
            bus.mem_s    <= '0;
            bus.req_ack  <= '0;
            bus.grant_id <= 3'd0;
            ptr          <= 3'd0;
        end else if (grant) begin
            bus.mem_w    <= 1'b1;
            bus.mem_sel  <= bus.req_addr[winner*AW +: AW];
            bus.mem_s    <= bus.req_data[winner*N +: N];
            bus.req_ack  <= NREQ'(1) << winner;
            bus.grant_id <= winner;
            ptr          <= rr_next(winner, NREQ);
        end else begin
            bus.mem_w    <= 1'b0;
            bus.req_ack  <= '0;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] cnt [NREQ];

    // Counters advance at the end of each ack pulse; a clear in that cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= 16'h0000;
        end else if (bus.stats_clr) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= 16'h0000;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ack[i] && cnt[i] != 16'hFFFF) begin
                    cnt[i] <= cnt[i] + 16'h0001;
                end
            end
        end
    end

    always_comb begin
        bus.grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.grant_cnt[i*16 +: 16] = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_arbitro_escritura_memoria.sv
// Directed plus randomized bench for arbitro_escritura_memoria against a cycle-level reference model.
// Covers grant_cnt/stats_clr as well when ARB_STATS_EN is defined.
module tb_arbitro_escritura_memoria;
    import arbitro_pkg::*;

    localparam int NREQ = 4;
    localparam int N    = 16;
    localparam int AW   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arbitro_escritura_memoria_if #(.NREQ(NREQ), .N(N), .AW(AW)) bus ();

    arbitro_escritura_memoria #(.NREQ(NREQ), .N(N), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int passed = 0;
    int failed = 0;

    int              m_ptr;
    bit              m_w;
    int              m_sel;
    int              m_s;
    int              m_gid;
    bit [NREQ-1:0]   m_ack;
    int              m_cnt [NREQ];
    int              bank [16];
    bit [NREQ-1:0]   pend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_w = 0; m_sel = 0; m_s = 0; m_gid = 0; m_ack = '0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    // Reference: winner is the first eligible index going round from ptr, modulo NREQ.
    task automatic model_edge();
        logic [NREQ-1:0] elig;
        int k;
`ifdef ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) begin
            if (bus.stats_clr) m_cnt[i] = 0;
            else if (m_ack[i] && m_cnt[i] < 65535) m_cnt[i]++;
        end
`endif
        elig = bus.req_valid & ~m_ack;
        if (bus.arb_en && elig != '0) begin
            k = -1;
            for (int j = 0; j < NREQ; j++) begin
                if (k < 0 && elig[(m_ptr + j) % NREQ]) k = (m_ptr + j) % NREQ;
            end
            m_w   = 1;
            m_sel = int'(bus.req_addr[k*AW +: AW]);
            m_s   = int'(bus.req_data[k*N +: N]);
            m_ack = '0;
            m_ack[k] = 1'b1;
            m_gid = k;
            m_ptr = (k + 1) % NREQ;
        end else begin
            m_w   = 0;
            m_ack = '0;
        end
    endtask

    task automatic check_output();
        check("mem_w",    bus.mem_w,    m_w);
        check("mem_sel",  bus.mem_sel,  m_sel);
        check("mem_s",    bus.mem_s,    m_s);
        check("req_ack",  bus.req_ack,  m_ack);
        check("grant_id", bus.grant_id, m_gid);
        check("busy",     bus.busy,     |(bus.req_valid & ~m_ack));
`ifdef ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) check("grant_cnt", bus.grant_cnt[i*16 +: 16], m_cnt[i]);
`endif
        if (bus.mem_w) bank[bus.mem_sel] = int'(bus.mem_s);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_output();
    endtask

    task automatic set_req(input int i, input bit v, input int a, input int d);
        bus.req_valid[i]          = v;
        bus.req_addr[i*AW +: AW]  = AW'(a);
        bus.req_data[i*N +: N]    = N'(d);
    endtask

    // Requesters hold until ack, then may change in the following cycle.
    task automatic apply_stimulus();
        @(negedge clk);
        bus.arb_en = ($urandom % 8) != 0;
`ifdef ARB_STATS_EN
        bus.stats_clr = ($urandom % 50) == 0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ack[i]) begin
                pend[i] = 1'b1;
            end else if (pend[i]) begin
                pend[i] = 1'b0;
                set_req(i, ($urandom % 4) != 0, int'($urandom % 16), int'($urandom % 65536));
            end else if (!bus.req_valid[i] && ($urandom % 3) == 0) begin
                set_req(i, 1'b1, int'($urandom % 16), int'($urandom % 65536));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit done;
        rst = 1'b1;
        bus.arb_en = 1'b0; bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
`ifdef ARB_STATS_EN
        bus.stats_clr = 1'b0;
`endif
        pend = '0;
        for (int i = 0; i < 16; i++) bank[i] = 0;
        model_reset();
        #3;
        check_output();
        @(negedge clk);
        rst = 1'b0;
        bus.arb_en = 1'b1;

        // Lone requester: one write every two cycles.
        set_req(0, 1'b1, 5, 16'hABCD);
        step();
        check("single_sel", bus.mem_sel, 5);
        check("single_s", bus.mem_s, 16'hABCD);
        check("single_ack", bus.req_ack, 4'b0001);
        step();
        check("single_gap", bus.mem_w, 0);
        for (int i = 0; i < 3; i++) step();
        check("rst_pre_w", bus.mem_w, 1);

        // Asynchronous reset with a write in flight.
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_w", bus.mem_w, 0);
        check("rst_ack", bus.req_ack, 0);
        check("rst_sel", bus.mem_sel, 0);
        check("rst_s", bus.mem_s, 0);
        check("rst_gid", bus.grant_id, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = '0;

        // All four valid: strict rotation from ptr=0.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i, 16'h1000 + i);
        for (int g = 0; g < 8; g++) begin
            step();
            check("rot_gid", bus.grant_id, g % NREQ);
            check("rot_w", bus.mem_w, 1);
        end
        @(negedge clk);
        bus.req_valid = '0;
        step();

        // Same-register collision: later grant's data is final.
        @(negedge clk);
        set_req(0, 1'b1, 3, 16'h1111);
        set_req(2, 1'b1, 3, 16'h2222);
        step();
        check("col_first", bus.grant_id, 0);
        check("col_bank1", bank[3], 16'h1111);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        step();
        check("col_second", bus.grant_id, 2);
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        step();
        check("col_bank", bank[3], 16'h2222);

        // arb_en low: requests wait and the pointer is kept.
        @(negedge clk);
        bus.arb_en = 1'b0;
        set_req(1, 1'b1, 9, 16'h0101);
        set_req(3, 1'b1, 10, 16'h0303);
        for (int i = 0; i < 5; i++) begin
            step();
            check("dis_w", bus.mem_w, 0);
            check("dis_ack", bus.req_ack, 0);
        end
        @(negedge clk);
        bus.arb_en = 1'b1;
        step();
        check("en_first", bus.grant_id, 3);
        step();
        check("en_second", bus.grant_id, 1);
        @(negedge clk);
        bus.req_valid = '0;
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            apply_stimulus();
            step();
        end

`ifdef ARB_STATS_EN
        // Counter reaches 7, then a clear during the 8th ack wins over the increment.
        @(negedge clk);
        bus.stats_clr = 1'b0;
        bus.arb_en = 1'b1;
        bus.req_valid = '0;
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        set_req(2, 1'b1, 7, 16'h7777);
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            if (m_ack[2] && m_cnt[2] == 7) begin
                check("stat_before", bus.grant_cnt[2*16 +: 16], 7);
                bus.stats_clr = 1'b1;
                step();
                check("stat_after", bus.grant_cnt[2*16 +: 16], 0);
                bus.stats_clr = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) check("stat_timeout", 0, 1);
        @(negedge clk);
        bus.req_valid = '0;
        step();
`else
        done = 1'b1;
        check("end_done", {31'd0, done}, 1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
